// File: rtl/btn_uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_uart_pkg : shared types and constants for the button-to-UART arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package btn_uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_CHAR = 2'd1,
    SEND_LF   = 2'd2
  } state_t;

  localparam logic [7:0] LF_BYTE = 8'h0A;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : first set request bit at or above ptr, wrapping around
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant
);

  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the closest match to ptr is written last.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) grant = idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_uart_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_uart_arbiter : round-robin arbiter turning button presses into TX bytes
// Revision: 1.0
// ---------------------------------------------------------------------------
module btn_uart_arbiter
  import btn_uart_pkg::*;
#(
  parameter int         N_BTN     = 4,
  parameter logic [7:0] CHAR_BASE = 8'h30,
  parameter bit         APPEND_LF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_pulse,
  input  logic             fifo_full,
  output logic             fifo_push,
  output logic [7:0]       fifo_wdata,
  output logic [N_BTN-1:0] pending,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    grant;
  logic [IW-1:0]    pick;
  logic [N_BTN-1:0] clr;
  logic [N_BTN-1:0] drop;
  logic [3:0]       drop_n;
  logic [8:0]       drop_sum;

  rr_pick #(
    .N  (N_BTN),
    .IW (IW)
  ) u_rr_pick (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (pick)
  );

  // Push depends only on state and FIFO back-pressure, never on fresh pulses.
  always_comb begin
    fifo_push  = 1'b0;
    fifo_wdata = 8'h00;
    if ((state == SEND_CHAR || state == SEND_LF) && !fifo_full) begin
      fifo_push  = 1'b1;
      fifo_wdata = (state == SEND_CHAR) ? (CHAR_BASE + 8'(grant)) : LF_BYTE;
    end
  end

  always_comb begin
    clr = '0;
    if (state == SEND_CHAR && fifo_push) clr[grant] = 1'b1;
    drop   = btn_pulse & pending & ~clr;
    drop_n = '0;
    for (int i = 0; i < N_BTN; i++) drop_n = drop_n + 4'(drop[i]);
    drop_sum = {1'b0, drop_cnt} + 9'(drop_n);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      drop_cnt <= 8'h00;
    end else begin
      // A new pulse on a bit being cleared re-arms it.
      pending  <= (pending & ~clr) | btn_pulse;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      case (state)
        IDLE: begin
          if (pending != '0) begin
            grant <= pick;
            state <= SEND_CHAR;
          end
        end
        SEND_CHAR: begin
          if (fifo_push) begin
            rr_ptr <= (grant == IW'(N_BTN - 1)) ? '0 : grant + IW'(1);
            state  <= APPEND_LF ? SEND_LF : IDLE;
          end
        end
        SEND_LF: begin
          if (fifo_push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_uart_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_btn_uart_arbiter : scoreboard bench for btn_uart_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_btn_uart_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_pulse;
  logic       fifo_full;
  logic       fifo_push;
  logic [7:0] fifo_wdata;
  logic [3:0] pending;
  logic       busy;
  logic [7:0] drop_cnt;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  btn_uart_arbiter #(
    .N_BTN     (4),
    .CHAR_BASE (8'h30),
    .APPEND_LF (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_pulse  (btn_pulse),
    .fifo_full  (fifo_full),
    .fifo_push  (fifo_push),
    .fifo_wdata (fifo_wdata),
    .pending    (pending),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every pushed byte must match the head of the scoreboard, in value and cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fifo_push) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_push actual=%0h expected=none (cycle %0d)", fifo_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("push_data", int'(fifo_wdata), int'(e.data));
          chk("push_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_wdata_zero", int'(fifo_wdata), 0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    btn_pulse = 4'b0000;
    fifo_full = 1'b0;
    step(2);
    chk("rst_push", int'(fifo_push), 0);
    chk("rst_wdata", int'(fifo_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    rst = 1'b0;
    step(1);

    // Simultaneous presses 0,1,3 from ptr 0
    t = cyc;
    btn_pulse = 4'b1011;
    expect_byte(8'h30, t + 2); expect_byte(8'h0A, t + 3);
    expect_byte(8'h31, t + 5); expect_byte(8'h0A, t + 6);
    expect_byte(8'h33, t + 8); expect_byte(8'h0A, t + 9);
    step; btn_pulse = 4'b0000;
    step(9);
    chk("burst_busy_done", int'(busy), 0);

    // Pointer wrapped back to 0, so button 1 goes before button 3
    t = cyc;
    btn_pulse = 4'b1010;
    expect_byte(8'h31, t + 2); expect_byte(8'h0A, t + 3);
    expect_byte(8'h33, t + 5); expect_byte(8'h0A, t + 6);
    step; btn_pulse = 4'b0000;
    step(6);

    // Single press on button 2
    t = cyc;
    btn_pulse = 4'b0100;
    expect_byte(8'h32, t + 2); expect_byte(8'h0A, t + 3);
    step; btn_pulse = 4'b0000;
    chk("single_pending_set", int'(pending), 4'b0100);
    step(3);
    chk("single_busy_low", int'(busy), 0);
    chk("single_pending_clr", int'(pending), 0);

    // FIFO stall from t+1 to t+6
    t = cyc;
    btn_pulse = 4'b0010;
    expect_byte(8'h31, t + 7); expect_byte(8'h0A, t + 8);
    step; btn_pulse = 4'b0000; fifo_full = 1'b1;
    step(3);
    chk("stall_busy", int'(busy), 1);
    chk("stall_pending", int'(pending), 4'b0010);
    step(3);
    fifo_full = 1'b0;
    step(2);

    // Set wins over clear in the cycle the char is pushed
    t = cyc;
    btn_pulse = 4'b0010;
    expect_byte(8'h31, t + 2); expect_byte(8'h0A, t + 3);
    expect_byte(8'h31, t + 5); expect_byte(8'h0A, t + 6);
    step; btn_pulse = 4'b0000;
    step; btn_pulse = 4'b0010;
    step; btn_pulse = 4'b0000;
    chk("soc_pending", int'(pending), 4'b0010);
    chk("soc_no_drop", int'(drop_cnt), 0);
    step(4);

    // Second press while stalled is dropped
    t = cyc;
    btn_pulse = 4'b0001;
    expect_byte(8'h30, t + 6); expect_byte(8'h0A, t + 7);
    step; btn_pulse = 4'b0000; fifo_full = 1'b1;
    step(2); btn_pulse = 4'b0001;
    step; btn_pulse = 4'b0000;
    chk("ovf_drop_one", int'(drop_cnt), 1);
    chk("ovf_pending", int'(pending), 4'b0001);
    step(2); fifo_full = 1'b0;
    step(3);

    // Three drops in a single cycle; ptr is 1 so order is 1,2,0
    t = cyc;
    fifo_full = 1'b1;
    btn_pulse = 4'b0111;
    expect_byte(8'h31, t + 3);  expect_byte(8'h0A, t + 4);
    expect_byte(8'h32, t + 6);  expect_byte(8'h0A, t + 7);
    expect_byte(8'h30, t + 9);  expect_byte(8'h0A, t + 10);
    step; btn_pulse = 4'b0000;
    step; btn_pulse = 4'b0111;
    step; btn_pulse = 4'b0000;
    chk("multi_drop", int'(drop_cnt), 4);
    fifo_full = 1'b0;
    step(8);

    // 300 further drops saturate the counter
    t = cyc;
    btn_pulse = 4'b0001;
    expect_byte(8'h30, t + 301); expect_byte(8'h0A, t + 302);
    step; fifo_full = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step;
      if (i == 99) chk("drop_partial", int'(drop_cnt), 104);
    end
    btn_pulse = 4'b0000;
    fifo_full = 1'b0;
    chk("drop_saturated", int'(drop_cnt), 255);
    step(3);
    chk("drop_held", int'(drop_cnt), 255);

    // Reset while SEND_LF is stalled: the LF is never sent
    t = cyc;
    btn_pulse = 4'b0100;
    expect_byte(8'h32, t + 2);
    step; btn_pulse = 4'b0000;
    step(2); fifo_full = 1'b1;
    step; rst = 1'b1;
    #1;
    chk("midrst_push", int'(fifo_push), 0);
    chk("midrst_wdata", int'(fifo_wdata), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pending", int'(pending), 0);
    chk("midrst_drop", int'(drop_cnt), 0);
    step; rst = 1'b0; fifo_full = 1'b0;
    step(3);
    chk("postrst_idle", int'(busy), 0);

    t = cyc;
    btn_pulse = 4'b0100;
    expect_byte(8'h32, t + 2); expect_byte(8'h0A, t + 3);
    step; btn_pulse = 4'b0000;
    step(3);
    chk("postrst_busy_low", int'(busy), 0);
    chk("postrst_pending", int'(pending), 0);

    step(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_uart_arbiter.md
BTN_UART_ARBITER -- requirements
Module: btn_uart_arbiter

Interface
REQ-001 Parameter N_BTN, default 4: number of button request inputs, range 2..8.
REQ-002 Parameter CHAR_BASE, default 8'h30: byte sent for button i is CHAR_BASE+i, modulo 256.
REQ-003 Parameter APPEND_LF, default 1: when 1, each button byte is followed by 8'h0A.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 btn_pulse  in  N_BTN  one-cycle press pulses from the per-button debounce/edge blocks; bit i = button i.
REQ-007 fifo_full  in  1  TX FIFO full flag; no write is accepted while high.
REQ-008 fifo_push  out  1  FIFO write strobe; a byte is written at each rising edge where it is high.
REQ-009 fifo_wdata  out  8  byte written when fifo_push is high.
REQ-010 pending  out  N_BTN  latched, not-yet-sent requests.
REQ-011 busy  out  1  high whenever the FSM is not IDLE.
REQ-012 drop_cnt  out  8  count of lost presses; saturates at 255.

Function
REQ-013 pending[i] SHALL be set at the edge after btn_pulse[i]=1 and cleared at the edge where the button-i byte is pushed.
REQ-014 If pulse and clear for the same bit coincide, set SHALL win and pending[i] stays 1.
REQ-015 If btn_pulse[i]=1 while pending[i]=1 and that bit is not being cleared in the same cycle, drop_cnt SHALL increment by 1, saturating at 255.
REQ-016 A single cycle with multiple such drops SHALL add the number of dropped bits, saturating at 255.
REQ-017 FSM states SHALL be IDLE, SEND_CHAR and SEND_LF.
REQ-018 IDLE: if pending!=0, the FSM SHALL capture grant = first set bit searching from rr_ptr upward with wrap-around, and go to SEND_CHAR.
REQ-019 IDLE: fifo_full SHALL NOT block the IDLE->SEND_CHAR transition.
REQ-020 SEND_CHAR: fifo_push = !fifo_full and fifo_wdata = CHAR_BASE+grant.
REQ-021 SEND_CHAR, on push: clear pending[grant], set rr_ptr = (grant+1) mod N_BTN, and go to SEND_LF if APPEND_LF=1, else to IDLE.
REQ-022 SEND_CHAR with fifo_full=1: the FSM SHALL hold state and grant with no push; grant SHALL NOT change while waiting.
REQ-023 SEND_LF: fifo_push = !fifo_full and fifo_wdata = 8'h0A; on push, go to IDLE; hold while full.
REQ-024 fifo_push SHALL be combinational from the state and fifo_full only, with no dependency on btn_pulse.
REQ-025 fifo_wdata SHALL be 8'h00 whenever fifo_push=0.
REQ-026 Latency: pulse in cycle t with FIFO not full gives the char push in cycle t+2 and the LF push in cycle t+3.
REQ-027 Back-to-back grants: IDLE SHALL last exactly one cycle between transactions, so the bus carries 2 bytes per 3 cycles with APPEND_LF=1.
REQ-028 A burst of simultaneous pulses SHALL be served in round-robin order with no button served twice before every pending button is served once.

Reset
REQ-029 On rst: state=IDLE, pending=0, rr_ptr=0, grant=0, drop_cnt=0, fifo_push=0, fifo_wdata=8'h00, busy=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it immediately; no push occurs in the reset cycle and the interrupted request is lost.
REQ-031 After deassertion, the first press SHALL be serviced per REQ-026.

Structure
REQ-032 Package btn_uart_pkg SHALL hold the FSM state typedef and the constant LF_BYTE = 8'h0A.
REQ-033 The round-robin pick SHALL be a combinational sub-module rr_pick, with inputs req[N_BTN] and ptr and output the grant index.
REQ-034 No other sub-modules; target size 150-250 lines of RTL.

Verification
REQ-035 Single press: pulse btn 2, fifo_full=0 -> push 8'h32 at t+2, push 8'h0A at t+3, busy low at t+4, pending=0.
REQ-036 Simultaneous press: pulse on bits 0,1,3 in one cycle, rr_ptr=0 -> byte order 30,0A,31,0A,33,0A; rr_ptr ends at 0.
REQ-037 FIFO stall: fifo_full=1 from t+1 to t+6 after a btn 1 pulse -> no push until t+7; 8'h31 pushed at t+7 and 8'h0A at t+8.
REQ-038 Overflow: pulse btn 0 twice while its request is stalled by fifo_full -> drop_cnt=1 and exactly one 8'h30 is sent; 300 such drops -> drop_cnt=255.
REQ-039 Set-over-clear: pulse btn 1 in the cycle its char is pushed -> pending[1] stays 1 and a second 8'h31 is sent.
REQ-040 Reset mid-operation: assert rst during SEND_LF with fifo_full=1 -> all outputs return to reset values, no 8'h0A is ever pushed, and the next press behaves per REQ-035.
